// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch stage: pc geometry, reset address and sequencer state encoding.
// Instruction memory and the pc sequencer both take PC_W from here.
package pc_sequencer_pkg;

    localparam int              PC_W     = 8;
    localparam int              OFF_W    = 16;
    localparam int              CNT_W    = 16;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    localparam logic [1:0] ST_HOLD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and fetch-address bundle between the pipeline control and the pc sequencer.
// master drives redirect/stall/halt requests; slave (the sequencer) returns the fetch address.
interface pc_sequencer_if #(
    parameter int CNT_W = pc_sequencer_pkg::CNT_W
);
    import pc_sequencer_pkg::*;

    logic                   stall;
    logic                   branch_taken;
    logic [OFF_W-1:0]       branch_offset;
    logic                   jump;
    logic [PC_W-1:0]        jump_target;
    logic                   halt;

    logic [PC_W-1:0]        pc;
    logic [PC_W-1:0]        pc_plus1;
    logic                   fetch_valid;
    logic                   halted;
    logic                   wrap;
    logic [CNT_W-1:0]       fetch_count;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target, halt,
        input  pc, pc_plus1, fetch_valid, halted, wrap, fetch_count
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target, halt,
        output pc, pc_plus1, fetch_valid, halted, wrap, fetch_count
    );

endinterface

// File: rtl/pc_sequencer_branch_adder.sv
// Combinational next-address arithmetic: pc+1 with carry-out, and the branch target
// pc+1+offset wrapped to the pc width.
module pc_branch_adder
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] branch_offset,
    output logic [PC_W-1:0]  pc_inc,
    output logic [PC_W-1:0]  pc_br,
    output logic             inc_ovf
);

    logic [PC_W-1:0] off_trunc;

    // Low PC_W bits of a sign-extended offset are just its low bits; the wrap is modulo 2**PC_W.
    assign off_trunc = branch_offset[PC_W-1:0];

    assign {inc_ovf, pc_inc} = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
    assign pc_br             = pc_inc + off_trunc;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding ins_mem: post-reset hold, sequential fetch, redirects with a
// one-cycle flush bubble, stall, halt, and a saturating count of valid fetches.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_HOLD  | post-reset settle; pc at RESET_PC, no fetch
//   ST_RUN   | normal fetch; halt > jump > branch > stall > increment
//   ST_FLUSH | bubble after a redirect; pc shows target, fetch not valid
//   ST_HALT  | frozen until reset
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = pc_sequencer_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_sequencer_if.slave   bus
);

    localparam int              HC_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             fv_q, fv_d;
    logic             halted_q, halted_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q;

    logic [PC_W-1:0]  pc_inc, pc_br, target;
    logic             inc_ovf, redirect;

    pc_branch_adder u_adder (
        .pc            (pc_q),
        .branch_offset (bus.branch_offset),
        .pc_inc        (pc_inc),
        .pc_br         (pc_br),
        .inc_ovf       (inc_ovf)
    );

    assign redirect = bus.jump | bus.branch_taken;
    assign target   = bus.jump ? bus.jump_target : pc_br;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pc_d       = pc_q;
        fv_d       = 1'b0;
        halted_d   = halted_q;
        wrap_d     = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (bus.halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                    fv_d    = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - HC_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (redirect) begin
                    state_d = ST_FLUSH;
                    pc_d    = target;
                end else if (!bus.stall) begin
                    pc_d   = pc_inc;
                    fv_d   = 1'b1;
                    wrap_d = inc_ovf;
                end
            end
            ST_FLUSH: begin
                if (bus.halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (redirect) begin
                    pc_d = target;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = pc_inc;
                    fv_d    = 1'b1;
                    wrap_d  = inc_ovf;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_LOAD;
            pc_q       <= RESET_PC;
            fv_q       <= 1'b0;
            halted_q   <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pc_q       <= pc_d;
            fv_q       <= fv_d;
            halted_q   <= halted_d;
            wrap_q     <= wrap_d;
            if (fv_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_inc;
    assign bus.fetch_valid = fv_q;
    assign bus.halted      = halted_q;
    assign bus.wrap        = wrap_q;
    assign bus.fetch_count = cnt_q;

endmodule
